conv_ff_bank: RTL and testbench

//  WIDTH-bit bank of flip-flops built on a T flip-flop core, with per-cycle

---
 rtl/conv_ff_pkg.sv | 15 +
 rtl/tff_cell.sv | 20 ++
 rtl/conv_ff_bank.sv | 95 +++++++++
 tb/tb_conv_ff_bank.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/conv_ff_pkg.sv
// Shared encodings for the convertible flip-flop bank: flop modes and the
// SR s=r=1 resolution policies.
package conv_ff_pkg;

  localparam logic [1:0] MODE_T  = 2'd0;
  localparam logic [1:0] MODE_D  = 2'd1;
  localparam logic [1:0] MODE_SR = 2'd2;
  localparam logic [1:0] MODE_JK = 2'd3;

  localparam int SR11_TOGGLE = 0;
  localparam int SR11_HOLD   = 1;
  localparam int SR11_RST    = 2;
  localparam int SR11_SET    = 3;

endpackage

// File: rtl/tff_cell.sv
// Single T flip-flop with update enable and synchronous load of its reset value.
// Latency 1; no flow control (en=0 simply holds).
module tff_cell (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic t,
  input  logic init,
  output logic q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= init;
    end else if (en) begin
      q <= q ^ t;
    end
  end

endmodule

// File: rtl/conv_ff_bank.sv
// Bank of T-flop cells driven through runtime-selectable T/D/SR/JK conversion,
// with sticky/saturating tracking of SR s=r=1 cycles. Latency 1; en=0 holds q.
module conv_ff_bank
  import conv_ff_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               CNT_W       = 4,
  parameter logic [WIDTH-1:0] INIT        = '0,
  parameter logic [1:0]       RESET_MODE  = MODE_SR,
  parameter int               SR11_POLICY = SR11_TOGGLE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode_ld,
  input  logic [1:0]       mode_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             illegal_clr,
  output logic [WIDTH-1:0] q,
  output logic [1:0]       mode,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] t_sr11;
  logic [WIDTH-1:0] t_sr;
  logic [WIDTH-1:0] t_jk;
  logic             ill_ev;

  // Toggle value applied to channels where s and r are both asserted.
  always_comb begin
    t_sr11 = '1;
    case (SR11_POLICY)
      SR11_HOLD: t_sr11 = '0;
      SR11_RST:  t_sr11 = q;
      SR11_SET:  t_sr11 = ~q;
      default:   t_sr11 = '1;
    endcase
  end

  assign t_sr = (a & ~b & ~q) | (b & ~a & q) | (a & b & t_sr11);
  assign t_jk = (a & ~q) | (b & q);

  always_comb begin
    t = '0;
    case (mode)
      MODE_T:  t = a;
      MODE_D:  t = a ^ q;
      MODE_SR: t = t_sr;
      default: t = t_jk;
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell u_cell (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .t    (t[i]),
      .init (INIT[i]),
      .q    (q[i])
    );
  end

  assign ill_ev = en && (mode == MODE_SR) && (|(a & b));

  always_ff @(posedge clk) begin
    if (rst) begin
      mode        <= RESET_MODE;
      illegal     <= 1'b0;
      illegal_cnt <= '0;
    end else begin
      if (mode_ld) begin
        mode <= mode_in;
      end
      // A same-cycle event takes priority over the clear.
      if (ill_ev) begin
        illegal <= 1'b1;
        if (illegal_clr) begin
          illegal_cnt <= CNT_W'(1);
        end else if (illegal_cnt != CNT_MAX) begin
          illegal_cnt <= illegal_cnt + CNT_W'(1);
        end
      end else if (illegal_clr) begin
        illegal     <= 1'b0;
        illegal_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_conv_ff_bank.sv
// Randomized plus directed bench for conv_ff_bank; one instance per SR policy,
// all fed the same stimulus and checked against a next-state reference model.
module tb_conv_ff_bank;

  localparam int NP = 4;
  localparam logic [7:0] INIT_V = 8'hA5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       mode_ld = 1'b0;
  logic [1:0] mode_in = 2'd0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       illegal_clr = 1'b0;

  logic [7:0] q_o       [NP];
  logic [1:0] mode_o    [NP];
  logic       illegal_o [NP];
  logic [3:0] cnt_o     [NP];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NP; g++) begin : g_dut
    conv_ff_bank #(
      .WIDTH(8), .CNT_W(4), .INIT(INIT_V), .RESET_MODE(2'd2), .SR11_POLICY(g)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .mode_ld     (mode_ld),
      .mode_in     (mode_in),
      .a           (a),
      .b           (b),
      .illegal_clr (illegal_clr),
      .q           (q_o[g]),
      .mode        (mode_o[g]),
      .illegal     (illegal_o[g]),
      .illegal_cnt (cnt_o[g])
    );
  end

  typedef struct packed {
    logic [NP-1:0][7:0] q;
    logic [1:0]         mode;
    logic               ill;
    logic [3:0]         cnt;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  logic [7:0] m_q [NP];
  logic [1:0] m_mode;
  logic       m_ill;
  int         m_cnt;

  task automatic chk(input string name, input int p, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s policy=%0d got=%h want=%h at %0t", name, p, act, exp, $time);
    end
  endtask

  // Next state of one flop from the characteristic tables of each mode.
  function automatic logic next_bit(input logic [1:0] md, input int pol,
                                    input logic qb, input logic x, input logic y);
    case (md)
      2'd0: return qb ^ x;
      2'd1: return x;
      2'd2: begin
        if (x && !y) return 1'b1;
        if (y && !x) return 1'b0;
        if (!x && !y) return qb;
        case (pol)
          0: return ~qb;
          1: return qb;
          2: return 1'b0;
          default: return 1'b1;
        endcase
      end
      default: begin
        if (x && y) return ~qb;
        if (x) return 1'b1;
        if (y) return 1'b0;
        return qb;
      end
    endcase
  endfunction

  task automatic step(input logic r, input logic e, input logic ml, input logic [1:0] mi,
                      input logic [7:0] aa, input logic [7:0] bb, input logic c);
    exp_t x;
    logic ev;
    @(negedge clk);
    rst = r; en = e; mode_ld = ml; mode_in = mi; a = aa; b = bb; illegal_clr = c;
    if (r) begin
      for (int p = 0; p < NP; p++) m_q[p] = INIT_V;
      m_mode = 2'd2;
      m_ill = 1'b0;
      m_cnt = 0;
    end else begin
      ev = e && (m_mode == 2'd2) && ((aa & bb) != 8'h00);
      if (e) begin
        for (int p = 0; p < NP; p++)
          for (int i = 0; i < 8; i++)
            m_q[p][i] = next_bit(m_mode, p, m_q[p][i], aa[i], bb[i]);
      end
      if (ev) begin
        m_ill = 1'b1;
        m_cnt = c ? 1 : ((m_cnt < 15) ? m_cnt + 1 : 15);
      end else if (c) begin
        m_ill = 1'b0;
        m_cnt = 0;
      end
      if (ml) m_mode = mi;
    end
    for (int p = 0; p < NP; p++) x.q[p] = m_q[p];
    x.mode = m_mode;
    x.ill  = m_ill;
    x.cnt  = 4'(m_cnt);
    sb.push_back(x);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        for (int p = 0; p < NP; p++) begin
          chk("q", p, 32'(q_o[p]), 32'(e.q[p]));
          chk("mode", p, 32'(mode_o[p]), 32'(e.mode));
          chk("illegal", p, 32'(illegal_o[p]), 32'(e.ill));
          chk("illegal_cnt", p, 32'(cnt_o[p]), 32'(e.cnt));
        end
      end
    end
  end

  initial begin : driver
    // Reset must win over en/mode_ld/illegal_clr.
    step(1, 1, 1, 2'd3, 8'hFF, 8'hFF, 1);
    step(1, 0, 0, 2'd0, 8'h00, 8'h00, 0);
    // Clear q through D mode, then return to SR.
    step(0, 0, 1, 2'd1, 8'h00, 8'h00, 0);
    step(0, 1, 0, 2'd0, 8'h00, 8'h00, 0);
    step(0, 0, 1, 2'd2, 8'h00, 8'h00, 0);
    step(0, 1, 0, 2'd0, 8'h0F, 8'hF0, 0);
    step(0, 1, 0, 2'd0, 8'h00, 8'h0F, 0);
    step(0, 1, 0, 2'd0, 8'h00, 8'h00, 0);
    // s=r=1 on channel 0 under each policy.
    step(0, 1, 0, 2'd0, 8'h01, 8'h01, 0);
    step(0, 1, 0, 2'd0, 8'h01, 8'h01, 0);
    // Mode load with en: old SR rule applies this edge.
    step(0, 1, 0, 2'd0, 8'h00, 8'h01, 1);
    step(0, 1, 1, 2'd1, 8'hFF, 8'h00, 0);
    step(0, 1, 0, 2'd0, 8'h3C, 8'h00, 0);
    step(0, 0, 1, 2'd0, 8'h00, 8'h00, 0);
    step(0, 1, 0, 2'd0, 8'hFF, 8'h5A, 0);
    // JK toggling, then frozen outputs with en=0.
    step(0, 0, 1, 2'd3, 8'h00, 8'h00, 0);
    for (int k = 0; k < 3; k++) step(0, 1, 0, 2'd0, 8'hFF, 8'hFF, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 2'd0, 8'($urandom), 8'($urandom), 0);
    // Counter saturation, clear racing an event, clear alone.
    step(0, 0, 1, 2'd2, 8'h00, 8'h00, 1);
    for (int k = 0; k < 20; k++) step(0, 1, 0, 2'd0, 8'h01, 8'h01, 0);
    step(0, 1, 0, 2'd0, 8'h81, 8'h81, 1);
    step(0, 1, 0, 2'd0, 8'h00, 8'h00, 1);
    step(0, 0, 0, 2'd0, 8'hFF, 8'hFF, 0);
    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      step(($urandom % 60) == 0, ($urandom % 4) != 0, ($urandom % 5) == 0,
           2'($urandom), 8'($urandom), 8'($urandom), ($urandom % 8) == 0);
    end
    step(0, 0, 0, 2'd0, 8'h00, 8'h00, 0);
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
